// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// sd_pkg : shared state encoding and line constants for the SD DAT receive path
// Rev 1.0
// ============================================================================
package sd_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_START = 3'd1,
      DATA       = 3'd2,
      CRC        = 3'd3,
      END        = 3'd4
   } sd_rx_state_t;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [3:0]  START_NIB  = 4'h0;
   localparam logic [3:0]  END_NIB    = 4'hF;

   // One serial step of CRC16-CCITT, data bit entering at the MSB side
   function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
      return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC16_POLY : 16'h0000);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sd_dat_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// sd_dat_rx_ctrl_if : word handshake between the DAT receiver and the RX FIFO
// Rev 1.0
// ============================================================================
interface sd_dat_rx_ctrl_if;

   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready;

   modport master (output word_data, output word_valid, input word_ready);
   modport slave  (input word_data, input word_valid, output word_ready);

endinterface
`default_nettype wire

// File: rtl/sd_crc16.sv
`default_nettype none
// ============================================================================
// sd_crc16 : serial CRC16-CCITT accumulator for one DAT line (init 0)
// Rev 1.0
// ============================================================================
module sd_crc16
   import sd_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        i_clr,
   input  wire logic        i_en,
   input  wire logic        i_bit,
   output logic [15:0]      o_crc
);

   logic [15:0] r_crc;

   always_ff @(posedge clk) begin
      if (!reset || i_clr) begin
         r_crc <= 16'h0000;
      end else if (i_en) begin
         r_crc <= crc16_step(r_crc, i_bit);
      end
   end

   assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_dat_rx_ctrl.sv
`default_nettype none
// ============================================================================
// sd_dat_rx_ctrl : SD 4-bit DAT receive sequencer (start bit, words, CRC16, end bit)
// Rev 1.0
// ============================================================================
module sd_dat_rx_ctrl
   import sd_pkg::*;
#(
   parameter int BLK_W     = 9,
   parameter int TIMEOUT_W = 16
) (
   input  wire logic                 clk,
   input  wire logic                 reset,
   input  wire logic                 i_start,
   input  wire logic [BLK_W-1:0]     i_blk_words,
   input  wire logic [TIMEOUT_W-1:0] i_timeout,
   input  wire logic [3:0]           i_dat_in,
   sd_dat_rx_ctrl_if.master          word_if,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_crc_err,
   output logic                      o_timeout_err,
   output logic                      o_overrun_err
);

   sd_rx_state_t         r_state;
   sd_rx_state_t         w_next_state;

   logic [BLK_W-1:0]     r_blk;
   logic [TIMEOUT_W-1:0] r_timeout;
   logic [TIMEOUT_W-1:0] r_wait_cnt;
   logic [2:0]           r_nib_cnt;
   logic [BLK_W:0]       r_word_cnt;
   logic [3:0]           r_crc_cnt;
   logic [27:0]          r_shift;
   logic [31:0]          r_word_data;
   logic                 r_word_valid;
   logic                 r_done;
   logic                 r_crc_err;
   logic                 r_timeout_err;
   logic                 r_overrun_err;

   logic                 w_start_acc;
   logic                 w_start_bit;
   logic [TIMEOUT_W-1:0] w_wait_next;
   logic                 w_timed_out;
   logic [BLK_W:0]       w_blk_total;
   logic [BLK_W:0]       w_word_next;
   logic                 w_word_done;
   logic                 w_last_word;
   logic                 w_crc_en;
   logic [15:0]          w_crc [4];
   logic [3:0]           w_crc_exp;
   logic                 w_crc_mis;

   assign w_start_acc = (r_state == IDLE) && i_start;
   assign w_start_bit = (i_dat_in == START_NIB);
   assign w_wait_next = r_wait_cnt + 1'b1;
   assign w_timed_out = (r_timeout != '0) && (w_wait_next == r_timeout);
   // A latched length of zero stands for the full 2**BLK_W words
   assign w_blk_total = {(r_blk == '0), r_blk};
   assign w_word_next = r_word_cnt + 1'b1;
   assign w_word_done = (r_state == DATA) && (r_nib_cnt == 3'd7);
   assign w_last_word = w_word_done && (w_word_next == w_blk_total);
   assign w_crc_en    = (r_state == DATA);

   for (genvar gi = 0; gi < 4; gi++) begin : g_crc
      sd_crc16 u_crc16 (
         .clk   (clk),
         .reset (reset),
         .i_clr (w_start_acc),
         .i_en  (w_crc_en),
         .i_bit (i_dat_in[gi]),
         .o_crc (w_crc[gi])
      );
      // Received CRC arrives MSB-first, so compare bit 15 on the first CRC cycle
      assign w_crc_exp[gi] = w_crc[gi][~r_crc_cnt];
   end

   assign w_crc_mis = |(w_crc_exp ^ i_dat_in);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:       if (i_start) w_next_state = WAIT_START;
         WAIT_START: begin
            if (w_start_bit)      w_next_state = DATA;
            else if (w_timed_out) w_next_state = IDLE;
         end
         DATA:       if (w_last_word) w_next_state = CRC;
         CRC:        if (r_crc_cnt == 4'd15) w_next_state = END;
         END:        w_next_state = IDLE;
         default:    w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_blk         <= '0;
         r_timeout     <= '0;
         r_wait_cnt    <= '0;
         r_nib_cnt     <= '0;
         r_word_cnt    <= '0;
         r_crc_cnt     <= '0;
         r_shift       <= '0;
         r_word_data   <= '0;
         r_word_valid  <= 1'b0;
         r_done        <= 1'b0;
         r_crc_err     <= 1'b0;
         r_timeout_err <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (word_if.word_ready) r_word_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_blk         <= i_blk_words;
                  r_timeout     <= i_timeout;
                  r_wait_cnt    <= '0;
                  r_crc_err     <= 1'b0;
                  r_timeout_err <= 1'b0;
                  r_overrun_err <= 1'b0;
               end
            end
            WAIT_START: begin
               r_wait_cnt <= w_wait_next;
               r_nib_cnt  <= '0;
               r_word_cnt <= '0;
               if (!w_start_bit && w_timed_out) begin
                  r_timeout_err <= 1'b1;
                  r_done        <= 1'b1;
               end
            end
            DATA: begin
               r_shift   <= {r_shift[23:0], i_dat_in};
               r_nib_cnt <= r_nib_cnt + 3'd1;
               r_crc_cnt <= '0;
               if (w_word_done) begin
                  r_word_cnt <= w_word_next;
                  // A word still held by the FIFO side wins; the new one is lost
                  if (!r_word_valid || word_if.word_ready) begin
                     r_word_data  <= {r_shift, i_dat_in};
                     r_word_valid <= 1'b1;
                  end else begin
                     r_overrun_err <= 1'b1;
                  end
               end
            end
            CRC: begin
               r_crc_cnt <= r_crc_cnt + 4'd1;
               if (w_crc_mis) r_crc_err <= 1'b1;
            end
            END: begin
               if (i_dat_in != END_NIB) r_crc_err <= 1'b1;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign word_if.word_data  = r_word_data;
   assign word_if.word_valid = r_word_valid;
   assign o_busy             = (r_state != IDLE);
   assign o_done             = r_done;
   assign o_crc_err          = r_crc_err;
   assign o_timeout_err      = r_timeout_err;
   assign o_overrun_err      = r_overrun_err;

endmodule
`default_nettype wire
